// File: rtl/linear_cordic_muldiv_pipe.sv
// Linear-mode CORDIC pipeline: per-transaction divide (vectoring) or multiply-accumulate (rotation).
// Optional macro CORDIC_DIV_ERR_EN adds err_out, which flags a divide by zero.
module linear_cordic_muldiv_pipe #(
  parameter int BIT_WIDTH = 27,
  parameter int FRAC_BITS = 23,
  parameter int ITERS     = 24,
  parameter int TAG_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  input  logic signed [BIT_WIDTH-1:0] x_in,
  input  logic signed [BIT_WIDTH-1:0] y_in,
  input  logic signed [BIT_WIDTH-1:0] z_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_mode,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic signed [BIT_WIDTH-1:0] x_out,
  output logic signed [BIT_WIDTH-1:0] y_out,
  output logic signed [BIT_WIDTH-1:0] z_out
`ifdef CORDIC_DIV_ERR_EN
  ,
  output logic                        err_out
`endif
);

  localparam logic signed [BIT_WIDTH-1:0] ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam int MSB = BIT_WIDTH - 1;

  logic [ITERS-1:0]            rdy;
  logic [ITERS-1:0]            v_q, m_q;
  logic [ITERS-1:0]            src_v, src_m;
  logic [TAG_WIDTH-1:0]        tag_q   [ITERS];
  logic [TAG_WIDTH-1:0]        src_tag [ITERS];
  logic signed [BIT_WIDTH-1:0] x_q   [ITERS];
  logic signed [BIT_WIDTH-1:0] y_q   [ITERS];
  logic signed [BIT_WIDTH-1:0] z_q   [ITERS];
  logic signed [BIT_WIDTH-1:0] src_x [ITERS];
  logic signed [BIT_WIDTH-1:0] src_y [ITERS];
  logic signed [BIT_WIDTH-1:0] src_z [ITERS];
  logic signed [BIT_WIDTH-1:0] y_d   [ITERS];
  logic signed [BIT_WIDTH-1:0] z_d   [ITERS];
`ifdef CORDIC_DIV_ERR_EN
  logic [ITERS-1:0]            err_q, src_err;
`endif

  // Ready chain: a stage may load if it, or any stage further downstream, is empty.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int k = ITERS - 1; k >= 0; k--) begin
      acc    = acc || !v_q[k];
      rdy[k] = acc;
    end
  end

  assign in_ready = rdy[0];

  always_comb begin
    src_v[0]   = in_valid;
    src_m[0]   = in_mode;
    src_tag[0] = in_tag;
    src_x[0]   = x_in;
    src_y[0]   = y_in;
    src_z[0]   = z_in;
`ifdef CORDIC_DIV_ERR_EN
    src_err[0] = !in_mode && (x_in == '0);
`endif
    for (int k = 1; k < ITERS; k++) begin
      src_v[k]   = v_q[k-1];
      src_m[k]   = m_q[k-1];
      src_tag[k] = tag_q[k-1];
      src_x[k]   = x_q[k-1];
      src_y[k]   = y_q[k-1];
      src_z[k]   = z_q[k-1];
`ifdef CORDIC_DIV_ERR_EN
      src_err[k] = err_q[k-1];
`endif
    end
  end

  // go_up selects y += xs, z -= e; otherwise y -= xs, z += e.
  always_comb begin
    logic signed [BIT_WIDTH-1:0] xs;
    logic signed [BIT_WIDTH-1:0] e;
    logic                        go_up;
    for (int k = 0; k < ITERS; k++) begin
      xs    = src_x[k] >>> k;
      e     = ONE >> k;
      go_up = src_m[k] ? !src_z[k][MSB] : (src_y[k][MSB] != src_x[k][MSB]);
      y_d[k] = go_up ? src_y[k] + xs : src_y[k] - xs;
      z_d[k] = go_up ? src_z[k] - e  : src_z[k] + e;
`ifdef CORDIC_DIV_ERR_EN
      if (src_err[k]) begin
        y_d[k] = src_y[k];
        z_d[k] = (k == 0) ? '0 : src_z[k];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      m_q <= '0;
`ifdef CORDIC_DIV_ERR_EN
      err_q <= '0;
`endif
      for (int k = 0; k < ITERS; k++) begin
        tag_q[k] <= '0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        z_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < ITERS; k++) begin
        if (rdy[k]) begin
          v_q[k]   <= src_v[k];
          m_q[k]   <= src_m[k];
          tag_q[k] <= src_tag[k];
          x_q[k]   <= src_x[k];
          y_q[k]   <= y_d[k];
          z_q[k]   <= z_d[k];
`ifdef CORDIC_DIV_ERR_EN
          err_q[k] <= src_err[k];
`endif
        end
      end
    end
  end

  assign out_valid = v_q[ITERS-1];
  assign out_mode  = m_q[ITERS-1];
  assign out_tag   = tag_q[ITERS-1];
  assign x_out     = x_q[ITERS-1];
  assign y_out     = y_q[ITERS-1];
  assign z_out     = z_q[ITERS-1];
`ifdef CORDIC_DIV_ERR_EN
  assign err_out   = err_q[ITERS-1];
`endif

endmodule

// File: tb/tb_linear_cordic_muldiv_pipe.sv
// Scoreboard bench for linear_cordic_muldiv_pipe; a reference model fills the queue, a monitor drains it.
module tb_linear_cordic_muldiv_pipe;
  localparam int W = 27;
  localparam int F = 23;
  localparam int N = 24;
  localparam int T = 4;
  localparam int TOL = N + 2;

  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0, in_ready, in_mode = 0;
  logic [T-1:0] in_tag = '0;
  logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic out_valid, out_ready = 1, out_mode;
  logic [T-1:0] out_tag;
  logic signed [W-1:0] x_out, y_out, z_out;
`ifdef CORDIC_DIV_ERR_EN
  logic err_out;
`endif

  linear_cordic_muldiv_pipe #(.BIT_WIDTH(W), .FRAC_BITS(F), .ITERS(N), .TAG_WIDTH(T)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_tag(out_tag),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
`ifdef CORDIC_DIV_ERR_EN
    , .err_out(err_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [T-1:0]  tag;
    logic signed [W-1:0] x, y, z;
    bit            err;
    int            issue;
    bit            lat;
    bit            apx_en;
    bit            apx_y;
    longint        apx;
  } exp_t;

  exp_t sb[$];
  int checks = 0, passes = 0;
  int cyc = 0, n_out = 0;
  bit bp_mode = 0, drop_seen = 0;
  int bp_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endfunction

  function automatic longint wrapw(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction

  // Straight transcription of the recurrence in wide integers, wrapped to W bits after each step.
  function automatic void ref_model(input bit m, input logic signed [W-1:0] x, y, z,
                                    output logic signed [W-1:0] yo, zo, output bit err);
    longint yy, zz, xs, e;
    bit up;
    err = 0;
`ifdef CORDIC_DIV_ERR_EN
    if (!m && x == 0) begin
      yo = y; zo = '0; err = 1;
      return;
    end
`endif
    yy = longint'(y);
    zz = longint'(z);
    for (int k = 0; k < N; k++) begin
      xs = longint'(x) >>> k;
      e  = longint'(1) <<< (F - k);
      up = m ? (zz >= 0) : ((yy < 0) != (x < 0));
      yy = wrapw(up ? yy + xs : yy - xs);
      zz = wrapw(up ? zz - e : zz + e);
    end
    yo = W'(yy);
    zo = W'(zz);
  endfunction

  task automatic send(input bit m, input logic [T-1:0] tag, input logic signed [W-1:0] x, y, z,
                      input bit lat, input bit apx_en, input bit apx_y, input longint apx);
    exp_t e;
    bit got;
    in_valid = 1; in_mode = m; in_tag = tag; x_in = x; y_in = y; z_in = z;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
      if (bp_mode && !drop_seen) begin
        drop_seen = 1;
        chk("in_ready_drop_count", 128'(bp_acc), 128'(N));
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL send_timeout tag=%0d in_ready actual=0 required=1", tag);
      in_valid = 0;
      return;
    end
    if (bp_mode) bp_acc++;
    e.mode = m; e.tag = tag; e.x = x;
    ref_model(m, x, y, z, e.y, e.z, e.err);
    e.issue = cyc; e.lat = lat; e.apx_en = apx_en; e.apx_y = apx_y; e.apx = apx;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout pending actual=%0d required=0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic rnd_send(input logic [T-1:0] tag, input bit m);
    logic signed [W-1:0] x, y, z;
    x = W'($urandom);
    y = W'($urandom);
    z = W'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      // Keep half the traffic inside the convergence range.
      x = W'($urandom_range(4194304, 12582912));
      if ($urandom_range(0, 1) == 1) x = -x;
      y = W'($signed(W'($urandom_range(0, 8388607))) - 4194304);
      z = W'($signed(W'($urandom_range(0, 16777215))) - 8388608);
    end
    send(m, tag, x, y, z, 0, 0, 0, 0);
  endtask

  // Monitor: pops on every output transfer and checks stability while stalled.
  initial begin
    exp_t e;
    logic [127:0] held;
    bit stalled;
    longint act, diff;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0;
        continue;
      end
      if (stalled)
        chk("stall_stable", {out_valid, out_mode, out_tag, x_out, y_out, z_out}, held);
      stalled = out_valid && !out_ready;
      if (stalled) held = {out_valid, out_mode, out_tag, x_out, y_out, z_out};
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output tag actual=%0d required=none", out_tag);
        end else begin
          e = sb.pop_front();
          chk("out_mode", out_mode, e.mode);
          chk("out_tag", out_tag, e.tag);
          chk("x_out", x_out, e.x);
          chk("y_out", y_out, e.y);
          chk("z_out", z_out, e.z);
`ifdef CORDIC_DIV_ERR_EN
          chk("err_out", err_out, e.err);
`endif
          if (e.lat) chk("latency", 128'(cyc - e.issue), 128'(N));
          if (e.apx_en) begin
            act  = e.apx_y ? longint'(y_out) : longint'(z_out);
            diff = act - e.apx;
            checks++;
            if (diff <= TOL && diff >= -TOL) passes++;
            else $display("FAIL approx_tag%0d actual=%0d required=%0d+-%0d", out_tag, act, e.apx, TOL);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_tag", out_tag, '0);
    chk("reset_z_out", z_out, '0);

    // Directed divides and multiply, isolated so latency is exact
    send(0, 4'd1, 27'sd8388608, 27'sd4194304, 27'sd0, 1, 1, 0, 4194304);
    idle(); wait_drain(100);
    send(0, 4'd2, -27'sd8388608, 27'sd4194304, 27'sd0, 1, 1, 0, -4194304);
    idle(); wait_drain(100);
    send(0, 4'd3, 27'sd4194304, -27'sd2097152, 27'sd0, 1, 1, 0, -4194304);
    idle(); wait_drain(100);
    send(1, 4'd4, 27'sd6291456, 27'sd2097152, 27'sd4194304, 1, 1, 1, 5242880);
    idle(); wait_drain(100);

    // Backpressure: 30 stalled cycles while streaming 40 transactions
    out_ready = 0;
    n0 = n_out;
    fork
      begin
        repeat (30) @(posedge clk);
        #1 out_ready = 1;
      end
    join_none
    bp_mode = 1; bp_acc = 0; drop_seen = 0;
    for (int i = 0; i < 40; i++) rnd_send(T'(i), i[0]);
    bp_mode = 0;
    idle();
    chk("in_ready_dropped", drop_seen, 1'b1);
    wait_drain(300);
    chk("bp_emitted", 128'(n_out - n0), 128'd40);

    // out_ready toggling every cycle
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
        out_ready = 1;
      end
    join_none
    for (int i = 0; i < 20; i++) rnd_send(T'(i + 5), 1'($urandom_range(0, 1)));
    idle();
    wait_drain(400);

    // Random out_ready
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1;
      end
    join_none
    for (int i = 0; i < 40; i++) rnd_send(T'(i), 1'($urandom_range(0, 1)));
    idle();
    wait_drain(600);

    // Reset mid-operation
    out_ready = 0;
    for (int i = 0; i < 10; i++) rnd_send(T'(i), i[0]);
    idle();
    reset = 1;
    sb.delete();
    @(posedge clk); #1;
    reset = 0;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_in_ready", in_ready, 1'b1);
    out_ready = 1;
    repeat (30) @(posedge clk);
    #1;
    send(0, 4'd9, 27'sd8388608, 27'sd2097152, 27'sd1048576, 1, 1, 0, 1048576 + 2097152);
    idle(); wait_drain(100);

`ifdef CORDIC_DIV_ERR_EN
    send(0, 4'd10, 27'sd0, 27'sd4194304, 27'sd0, 1, 0, 0, 0);
    idle(); wait_drain(100);
    send(0, 4'd11, 27'sd8388608, 27'sd4194304, 27'sd0, 1, 1, 0, 4194304);
    idle(); wait_drain(100);
    send(1, 4'd12, 27'sd0, 27'sd4194304, 27'sd4194304, 1, 1, 1, 4194304);
    idle(); wait_drain(100);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
